// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache/memory arbitration slice: arbiter state
// encoding and block geometry. MEM_LAT describes the memory4c read latency and
// is consumed by simulation models only.
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        I_FILL  = 2'b01,
        D_FILL  = 2'b10,
        D_WRITE = 2'b11
    } arb_state_e;

    localparam int WORDS     = 8;   // 16-bit words per cache block
    localparam int BLK_OFF_W = 4;   // byte-offset bits within a block
    localparam int MEM_LAT   = 4;   // memory4c enable-to-data_valid cycles

endpackage

// File: rtl/burst_counter.sv
// -----------------------------------------------------------------------------
// burst_counter
// Small up-counter used to walk the words of a block burst.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the count
//   clr_i   : synchronous clear (wins over inc_i)
//   inc_i   : advance the count by one (wraps after the last word)
//   cnt_o   : current count
//   last_o  : count is at its final value (all ones)
// -----------------------------------------------------------------------------
module burst_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one pipelined memory4c between the I-cache and D-cache fill FSMs.
// Grants one requester at a time (round-robin on ties), issues the 8 reads of
// a block fill back to back, and steers returned words plus their beat index to
// the owning cache. D-cache single-word writes take one cycle.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   i_req, i_addr               I-cache fill request / miss address
//   d_req, d_wr, d_addr,
//   d_wdata                     D-cache request (d_wr=1 write, 0 fill)
//   i_grant, d_grant            which cache currently owns memory
//   i_data_valid, d_data_valid  returned word valid for that cache
//   rdata, beat                 returned word and its index within the block
//   i_done, d_done              one-cycle completion pulses
//   mem_addr, mem_wdata,
//   mem_enable, mem_wr          memory4c request side
//   mem_rdata, mem_data_valid   memory4c response side
//
// State table
//   state   | meaning
//   IDLE    | no owner; arbitrate pending requests
//   I_FILL  | I-cache block fill: issue 8 reads, collect 8 returns
//   D_FILL  | D-cache block fill: issue 8 reads, collect 8 returns
//   D_WRITE | D-cache single-word write, one cycle
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = cache_pkg::WORDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic                       d_req,
    input  logic                       d_wr,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic [DATA_W-1:0]          d_wdata,
    output logic                       i_grant,
    output logic                       d_grant,
    output logic                       i_data_valid,
    output logic                       d_data_valid,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(WORDS)-1:0]   beat,
    output logic                       i_done,
    output logic                       d_done,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_enable,
    output logic                       mem_wr,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_data_valid
);

    import cache_pkg::*;

    localparam int CNT_W = $clog2(WORDS);

    arb_state_e                     state_q, state_d;
    logic [ADDR_W-1:BLK_OFF_W]      base_q, base_d;
    logic                           last_d_q, last_d_d;
    logic                           iss_done_q, iss_done_d;

    logic [CNT_W-1:0]               iss_cnt;
    logic [CNT_W-1:0]               ret_cnt;
    logic                           iss_last;
    logic                           ret_last;
    logic                           in_fill;
    logic                           iss_inc;
    logic                           ret_inc;
    logic                           cnt_clr;

    // Fill requests always start at word 0 of the block, so the I-side offset
    // bits carry no information here.
    logic                           unused_i_off;
    assign unused_i_off = ^i_addr[BLK_OFF_W-1:0];

    assign in_fill = (state_q == I_FILL) || (state_q == D_FILL);
    assign iss_inc = in_fill && !iss_done_q;
    // Returns are only counted while a fill owns memory; stray valids left
    // over from an aborted fill land in IDLE and are dropped.
    assign ret_inc = in_fill && mem_data_valid;
    assign cnt_clr = (state_q == IDLE);

    burst_counter #(.W(CNT_W)) u_iss_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (iss_inc),
        .cnt_o  (iss_cnt),
        .last_o (iss_last)
    );

    burst_counter #(.W(CNT_W)) u_ret_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (ret_inc),
        .cnt_o  (ret_cnt),
        .last_o (ret_last)
    );

    assign i_grant = (state_q == I_FILL);
    assign d_grant = (state_q == D_FILL) || (state_q == D_WRITE);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        last_d_d     = last_d_q;
        iss_done_d   = iss_done_q;

        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        rdata        = '0;
        beat         = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;

        case (state_q)
            IDLE: begin
                iss_done_d = 1'b0;
                // On a tie the cache that did not win last time goes first.
                if (i_req && (!d_req || last_d_q)) begin
                    state_d  = I_FILL;
                    base_d   = i_addr[ADDR_W-1:BLK_OFF_W];
                    last_d_d = 1'b0;
                end else if (d_req) begin
                    state_d  = d_wr ? D_WRITE : D_FILL;
                    base_d   = d_addr[ADDR_W-1:BLK_OFF_W];
                    last_d_d = 1'b1;
                end
            end

            I_FILL, D_FILL: begin
                if (!iss_done_q) begin
                    mem_enable = 1'b1;
                    mem_addr   = {base_q, iss_cnt, 1'b0};
                    if (iss_last) begin
                        iss_done_d = 1'b1;
                    end
                end
                // The transaction ignores req from here on: issued reads
                // cannot be recalled, so the fill always runs to the end.
                if (mem_data_valid) begin
                    rdata = mem_rdata;
                    beat  = ret_cnt;
                    if (state_q == I_FILL) begin
                        i_data_valid = 1'b1;
                    end else begin
                        d_data_valid = 1'b1;
                    end
                    if (ret_last) begin
                        if (state_q == I_FILL) begin
                            i_done = 1'b1;
                        end else begin
                            d_done = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end

            D_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                d_done     = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            last_d_q   <= 1'b0;
            iss_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            last_d_q   <= last_d_d;
            iss_done_q <= iss_done_d;
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single multi-cycle, pipelined main memory (`memory4c`, 16-bit words, 4-cycle read latency) between the I-cache and D-cache. Accepts whole-block fill requests from either cache and single-word write-through requests from the D-cache, and grants one requester at a time. For a fill, it generates the 8 word addresses of the block and steers the returned data and beat index back to the granted cache. It sits between the two `cache_fill_fsm` instances and the one `memory4c` instance.

## Interface
- `ADDR_W`, 16, byte address width
- `DATA_W`, 16, word width
- `WORDS`, 8, words per block (16-byte block, offset = addr[3:0])
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `i_req`  in  1  I-cache fill request, held until `i_done`
- `i_addr`  in  16  I-cache miss address
- `d_req`  in  1  D-cache request, held until `d_done`
- `d_wr`  in  1  1 = single-word write, 0 = block fill
- `d_addr`  in  16  D-cache address
- `d_wdata`  in  16  D-cache write data
- `i_grant`, `d_grant`  out  1  owner of memory this cycle
- `i_data_valid`, `d_data_valid`  out  1  returned word valid for that cache
- `rdata`  out  16  returned word (shared bus)
- `beat`  out  3  word index of `rdata` within block
- `i_done`, `d_done`  out  1  one-cycle completion pulse
- `mem_addr`  out  16  to memory addr
- `mem_wdata`  out  16  to memory data_in
- `mem_enable`, `mem_wr`  out  1  to memory enable/wr
- `mem_rdata`  in  16  from memory data_out
- `mem_data_valid`  in  1  from memory data_valid

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. Registers: `state`, `iss_cnt`[2:0], `ret_cnt`[2:0], `iss_done`, `base`[15:4], `last_d` (last winner was D).
- IDLE:
  - With only one request pending, that request wins.
  - With both pending, the winner is I if `last_d`=1, else D. Round-robin.
  - On a D win: D_WRITE if `d_wr`=1, else D_FILL. On an I win: I_FILL.
  - Latch `base` = winner addr[15:4] and update `last_d`.
- Fill states:
  - Issue one read per cycle: `mem_enable`=1, `mem_wr`=0, `mem_addr` = {`base`, `iss_cnt`, 1'b0}.
  - `iss_cnt` counts 0..7. After the read with `iss_cnt`=7, set `iss_done` and hold `mem_enable`=0.
  - Each `mem_data_valid` asserts the owner's `*_data_valid`, drives `rdata`=`mem_rdata` and `beat`=`ret_cnt`, then increments `ret_cnt`.
  - The valid with `ret_cnt`=7 pulses the owner's `*_done` in the same cycle; next state is IDLE.
- D_WRITE: held for one cycle.
  - `mem_enable`=1, `mem_wr`=1, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`.
  - `d_done` pulses in the same cycle; next state is IDLE.
- `mem_wdata`=0 outside D_WRITE.
- `*_grant` = (state is owned by that cache). Combinational from `state`.
- Dropping `req` mid-transaction is ignored: the transaction always completes, because memory reads cannot be cancelled.
- `mem_data_valid` in IDLE or D_WRITE is ignored and produces no output.

## Timing
- Reset: state IDLE, counters 0, `iss_done`=0, `last_d`=0, `base`=0. Every output is 0, including `rdata` and `beat`.
- Grant latency: `req` seen in IDLE at cycle N gives grant and the first issue at cycle N+1.
- Fill with the state entered at T:
  - Issues at T..T+7.
  - `memory4c` returns valid 4 cycles after each enable, so data arrives at T+4..T+11, beats 0..7 in order.
  - `*_done` at T+11, IDLE at T+12.
- Write: entered at T, `d_done` at T+0, IDLE at T+1.
- One IDLE cycle always separates transactions. Same-cycle handoff is not allowed.
- Starvation bound: a waiting requester is granted within 14 cycles of the other's grant.
- Reset mid-fill: abort to IDLE next edge. Stale data valids arriving afterwards are ignored.

## Structure
- Shared package `cache_pkg`:
  - state encoding: IDLE=2'b00, I_FILL=2'b01, D_FILL=2'b10, D_WRITE=2'b11
  - `WORDS`, `BLK_OFF_W`=4, `MEM_LAT`=4 (bench use only)
- One sub-module, `burst_counter`: a 3-bit counter with clear, increment and `last` (==7) outputs.
  - Instantiated twice, once for issue and once for return.

## Test plan
- Single I fill: `i_req` with `i_addr`=0x1236.
  - `mem_addr` 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
  - `i_data_valid` beats 0..7 with data matching memory.
  - `i_done` exactly 11 cycles after the first issue; `d_*` all 0.
- Simultaneous `i_req` and `d_req` (fill) out of reset:
  - D granted first (`last_d`=0).
  - I granted 2 cycles after `d_done`.
  - Repeating the tie then grants I first.
- D write: `d_wr`=1, `d_addr`=0x0044, `d_wdata`=0xBEEF.
  - One cycle with `mem_wr`=1, `mem_addr`=0x0044, `mem_wdata`=0xBEEF.
  - `d_done` in the same cycle; memory word reads back 0xBEEF.
- Requester drops `i_req` at beat 3: fill still completes all 8 beats, and `i_done` pulses at T+11.
- `rst` asserted at T+5 of a D fill:
  - All outputs 0 next cycle, state IDLE.
  - Later stray `mem_data_valid` produces no `*_data_valid`.
  - A new `i_req` is granted normally.
